// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: pulses each pipeline stage's enable in turn,
// waits for its done flag, owns the architectural PC and counts retired instructions.
module stage_sequencer #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    input  logic             halt_req,
    output logic             fetch_en,
    input  logic             fetch_done,
    output logic             decode_en,
    input  logic             decode_done,
    input  logic             is_mem,
    output logic             exec_en,
    input  logic             exec_done,
    input  logic             jump_taken,
    input  logic [31:0]      jump_target,
    output logic             mem_en,
    input  logic             mem_done,
    output logic             wb_en,
    input  logic             wb_done,
    output logic [31:0]      pc,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    localparam int unsigned       WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [31:0]       r_pc;
    logic [CNT_W-1:0]  r_retired;
    logic              r_halt_pending;
    logic              r_is_mem;
    logic              r_jump_taken;
    logic [31:0]       r_jump_target;

    logic w_first;
    logic w_done;
    logic w_busy;
    logic w_ack;
    logic w_timeout;
    logic w_bad_jump;

    // r_wait is zero only in the entry cycle of a state, which is the enable-pulse
    // cycle; a done flag seen then is stale and is ignored.
    always_comb begin
        w_first = (r_wait == '0);
        w_busy  = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC) ||
                  (r_state == S_MEM) || (r_state == S_WB);
        w_done  = 1'b0;
        case (r_state)
            S_FETCH:  w_done = fetch_done;
            S_DECODE: w_done = decode_done;
            S_EXEC:   w_done = exec_done;
            S_MEM:    w_done = mem_done;
            S_WB:     w_done = wb_done;
            default:  w_done = 1'b0;
        endcase
        w_ack      = w_busy && !w_first && w_done;
        w_timeout  = w_busy && !w_ack && (r_wait == WAIT_MAX);
        w_bad_jump = (r_state == S_EXEC) && w_ack && jump_taken && (jump_target[1:0] != 2'b00);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH:  if (w_ack) w_next = S_DECODE;
            S_DECODE: if (w_ack) w_next = S_EXEC;
            S_EXEC:   if (w_ack) w_next = w_bad_jump ? S_ERR : (r_is_mem ? S_MEM : S_WB);
            S_MEM:    if (w_ack) w_next = S_WB;
            S_WB:     if (w_ack) w_next = (r_halt_pending || halt_req) ? S_HALT : S_FETCH;
            S_HALT:   if (run && !halt_req) w_next = S_FETCH;
            S_ERR:    w_next = S_ERR;
            default:  w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_wait         <= '0;
            r_pc           <= PC_RESET;
            r_retired      <= '0;
            r_halt_pending <= 1'b0;
            r_is_mem       <= 1'b0;
            r_jump_taken   <= 1'b0;
            r_jump_target  <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) r_wait <= '0;
            else if (w_busy)       r_wait <= r_wait + WAIT_W'(1);
            if (r_state == S_DECODE && w_ack) r_is_mem <= is_mem;
            if (r_state == S_EXEC && w_ack) begin
                r_jump_taken  <= jump_taken;
                r_jump_target <= jump_target;
            end
            if (r_state == S_WB && w_ack) begin
                r_pc      <= r_jump_taken ? r_jump_target : r_pc + 32'd4;
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_next == S_HALT && r_state != S_HALT) r_halt_pending <= 1'b0;
            else if (w_busy && halt_req)                r_halt_pending <= 1'b1;
        end
    end

    always_comb begin
        fetch_en    = (r_state == S_FETCH)  && w_first;
        decode_en   = (r_state == S_DECODE) && w_first;
        exec_en     = (r_state == S_EXEC)   && w_first;
        mem_en      = (r_state == S_MEM)    && w_first;
        wb_en       = (r_state == S_WB)     && w_first;
        busy        = w_busy;
        halted      = (r_state == S_HALT);
        error       = (r_state == S_ERR);
        pc          = r_pc;
        retired     = r_retired;
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a stage responder answers enable pulses with
// done after a per-stage latency; the main sequence checks timing, PC and counters.
module tb_stage_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        run = 1'b0;
    logic        halt_req = 1'b0;
    logic        is_mem = 1'b0;
    logic        jump_taken = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
    logic        busy, halted, error;
    logic [31:0] pc;
    logic [31:0] retired;
    logic [2:0]  dbg_state;
    logic [4:0]  done_v = 5'h0;
    logic [4:0]  w_en;
    logic        hold_done = 1'b0;

    int lat[5] = '{1, 1, 1, 1, 1};
    int cnt[5] = '{0, 0, 0, 0, 0};
    int n_assert = 0;
    int n_fail = 0;
    int multi_en = 0;

    assign w_en = {wb_en, mem_en, exec_en, decode_en, fetch_en};

    stage_sequencer #(.PC_RESET(32'h0), .TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .run(run), .halt_req(halt_req),
        .fetch_en(fetch_en), .fetch_done(done_v[0]),
        .decode_en(decode_en), .decode_done(done_v[1]), .is_mem(is_mem),
        .exec_en(exec_en), .exec_done(done_v[2]),
        .jump_taken(jump_taken), .jump_target(jump_target),
        .mem_en(mem_en), .mem_done(done_v[3]),
        .wb_en(wb_en), .wb_done(done_v[4]),
        .pc(pc), .busy(busy), .halted(halted), .error(error),
        .retired(retired), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Stage responder: done pulses lat[i] cycles after the enable (lat 0 = never).
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                for (int i = 0; i < 5; i++) cnt[i] = 0;
                done_v = 5'h0;
            end else begin
                done_v = hold_done ? 5'h1f : 5'h00;
                for (int i = 0; i < 5; i++) begin
                    if (cnt[i] > 0) begin
                        cnt[i] = cnt[i] - 1;
                        if (cnt[i] == 0) done_v[i] = 1'b1;
                    end
                    if (w_en[i] && lat[i] > 0) cnt[i] = lat[i];
                end
            end
        end
    end

    always @(negedge clk) if (rstn && $countones(w_en) > 1) multi_en++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        run = 1'b0;
        halt_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, {27'h0, w_en}, 32'h0);
        check({tag, "_flags"}, {29'h0, busy, halted, error}, 32'h0);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_retired"}, retired, 32'h0);
    endtask

    // Steps until the next fetch_en, halt or error; counts cycles and enable pulses seen before it.
    task automatic observe(output int n, output int pulses, output int mems);
        n = 0;
        pulses = 0;
        mems = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (fetch_en || halted || error) break;
            pulses += $countones(w_en);
            mems += int'(mem_en);
        end
    endtask

    task automatic wait_en(input int idx, output int n);
        n = 0;
        while (!w_en[idx] && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic start_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    int n, p, m;

    initial begin
        // reset state
        do_reset();
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);
        check("idle_no_en", {27'h0, w_en}, 32'h0);

        // sequential non-mem instructions, 1-cycle stages
        start_run();
        check("t1_fetch_en", {31'h0, fetch_en}, 32'h1);
        check("t1_pc0", pc, 32'h0);
        check("t1_busy", {31'h0, busy}, 32'h1);
        observe(n, p, m);
        check("t1_cycles_i0", n, 8);
        check("t1_pulses_i0", p, 3);
        check("t1_pc4", pc, 32'h4);
        check("t1_retired1", retired, 32'd1);
        observe(n, p, m);
        check("t1_cycles_i1", n, 8);
        check("t1_pc8", pc, 32'h8);
        check("t1_retired2", retired, 32'd2);

        // load/store with mem_done five cycles late
        is_mem = 1'b1;
        lat[3] = 6;
        observe(n, p, m);
        check("t2_cycles", n, 15);
        check("t2_pulses", p, 4);
        check("t2_mem_pulses", m, 1);
        check("t2_pc", pc, 32'hC);
        check("t2_retired", retired, 32'd3);

        // level-held done flags: pulse-cycle done must be ignored
        is_mem = 1'b0;
        lat[3] = 1;
        hold_done = 1'b1;
        observe(n, p, m);
        check("level_done_cycles", n, 8);
        check("level_done_pc", pc, 32'h10);
        hold_done = 1'b0;

        // taken jump, then misaligned jump
        jump_taken = 1'b1;
        jump_target = 32'h100;
        observe(n, p, m);
        check("t3_jump_pc", pc, 32'h100);
        check("t3_jump_retired", retired, 32'd5);
        jump_target = 32'h102;
        observe(n, p, m);
        check("t3_misalign_cycles", n, 6);
        check("t3_misalign_error", {31'h0, error}, 32'h1);
        check("t3_misalign_pc", pc, 32'h100);
        check("t3_misalign_retired", retired, 32'd5);
        p = 0;
        repeat (10) begin
            @(negedge clk);
            p += $countones(w_en);
        end
        check("t3_err_no_pulses", p, 0);
        check("t3_err_sticky", {30'h0, error, busy}, 32'h2);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("t3_err_ignores_run", {30'h0, error, fetch_en}, 32'h2);

        // halt request during EXEC
        do_reset();
        rstn = 1'b1;
        jump_taken = 1'b0;
        jump_target = 32'h0;
        start_run();
        check("t4_fetch_en", {31'h0, fetch_en}, 32'h1);
        wait_en(2, n);
        check("t4_exec_at", n, 4);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        observe(n, p, m);
        check("t4_halt_cycles", n, 3);
        check("t4_halted", {29'h0, halted, busy, fetch_en}, 32'h4);
        check("t4_retired", retired, 32'd1);
        check("t4_pc", pc, 32'h4);
        p = 0;
        repeat (5) begin
            @(negedge clk);
            p += $countones(w_en);
        end
        check("t4_halt_no_pulses", p, 0);
        run = 1'b1;
        halt_req = 1'b1;
        @(negedge clk);
        check("t4_halt_priority", {30'h0, halted, fetch_en}, 32'h2);
        halt_req = 1'b0;
        @(negedge clk);
        run = 1'b0;
        check("t4_resume_fetch", {30'h0, halted, fetch_en}, 32'h1);
        check("t4_resume_pc", pc, 32'h4);
        observe(n, p, m);
        check("t4_no_stale_halt", {30'h0, halted, fetch_en}, 32'h1);

        // fetch watchdog
        do_reset();
        rstn = 1'b1;
        lat[0] = 0;
        start_run();
        check("t5_fetch_en", {31'h0, fetch_en}, 32'h1);
        observe(n, p, m);
        check("t5_timeout_cycles", n, TO + 1);
        check("t5_error", {31'h0, error}, 32'h1);
        check("t5_pc", pc, 32'h0);
        do_reset();
        check_reset_outputs("t5_reset");
        lat[0] = 1;
        rstn = 1'b1;

        // reset in the middle of MEM
        start_run();
        observe(n, p, m);
        check("t6_first_retired", retired, 32'd1);
        is_mem = 1'b1;
        lat[3] = 0;
        wait_en(3, n);
        check("t6_mem_at", n, 6);
        repeat (3) @(negedge clk);
        do_reset();
        check_reset_outputs("t6_reset");
        rstn = 1'b1;
        is_mem = 1'b0;
        lat[3] = 1;
        p = 0;
        repeat (5) begin
            @(negedge clk);
            p += $countones(w_en);
        end
        check("t6_idle_no_pulses", p, 0);

        // PC wraps from 32'hFFFF_FFFC to 0
        jump_taken = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        start_run();
        observe(n, p, m);
        check("t6_pc_top", pc, 32'hFFFF_FFFC);
        jump_taken = 1'b0;
        observe(n, p, m);
        check("t6_pc_wrap", pc, 32'h0);
        check("t6_wrap_retired", retired, 32'd2);

        check("one_hot_enables", multi_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
